// File: rtl/hazard_pkg.sv
// Shared types and field positions for the pipeline hazard-control unit.
package hazard_pkg;

    typedef enum logic {
        IDLE,
        LU_HOLD
    } state_t;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int CNT_W = $clog2(8);

    function automatic bit lat_ok(input int lat);
        return (lat >= 1) && (lat <= 7);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Register-operand comparator; r0 is never a real producer.
module hazard_match #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] dst,
    input  logic             use_src,
    output logic             hit
);

    assign hit = use_src && (src == dst) && (dst != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / RAW hazard control for the 5-stage pipeline: stalls,
// bubbles, branch flush, memory freeze and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       ifid_inst_i,
    input  logic              ifid_use_rs_i,
    input  logic              ifid_use_rt_i,
    input  logic [REG_W-1:0]  idex_dst_i,
    input  logic              idex_memread_i,
    input  logic              idex_regwrite_i,
    input  logic [REG_W-1:0]  exmem_dst_i,
    input  logic              exmem_regwrite_i,
    input  logic              mem_stall_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_freeze_o,
    output logic [PERF_W-1:0] perf_stall_o
);

    if (!lat_ok(LOAD_LAT)) begin : g_bad_lat
        $error("hazard_ctrl: LOAD_LAT must be in 1..7");
    end

    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             unused_inst;

    assign rs = REG_W'(ifid_inst_i[RS_HI:RS_LO]);
    assign rt = REG_W'(ifid_inst_i[RT_HI:RT_LO]);
    assign unused_inst = ^{ifid_inst_i[31:26], ifid_inst_i[15:0]};

    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;

    hazard_match #(.REG_W(REG_W)) u_rs_ex (
        .src(rs), .dst(idex_dst_i), .use_src(ifid_use_rs_i), .hit(rs_ex_hit)
    );
    hazard_match #(.REG_W(REG_W)) u_rt_ex (
        .src(rt), .dst(idex_dst_i), .use_src(ifid_use_rt_i), .hit(rt_ex_hit)
    );
    hazard_match #(.REG_W(REG_W)) u_rs_mem (
        .src(rs), .dst(exmem_dst_i), .use_src(ifid_use_rs_i), .hit(rs_mem_hit)
    );
    hazard_match #(.REG_W(REG_W)) u_rt_mem (
        .src(rt), .dst(exmem_dst_i), .use_src(ifid_use_rt_i), .hit(rt_mem_hit)
    );

    logic ex_hit, mem_hit, lu, raw;

    assign ex_hit  = rs_ex_hit || rt_ex_hit;
    assign mem_hit = rs_mem_hit || rt_mem_hit;
    assign lu      = idex_memread_i && ex_hit;
    assign raw     = (FWD_EN != 0) ? lu
                   : (lu || (idex_regwrite_i && ex_hit)
                         || (exmem_regwrite_i && mem_hit));

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             stall;

    assign stall = (state == LU_HOLD) || raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (mem_stall_i) begin
            // Memory wait: everything holds, the FSM included.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            unique case (state)
                IDLE: begin
                    if (lu && (LOAD_LAT > 1)) begin
                        state_n = LU_HOLD;
                        cnt_n   = CNT_W'(LOAD_LAT - 1);
                    end
                end
                LU_HOLD: begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (!pc_write_o && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign perf_stall_o = perf_q;

endmodule
